// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline: divide sequencing, load-use interlock,
// exception redirect and fetch drain. Optional stall-cycle perf counter under HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned DIV_CNT_W  = 6
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_busy,
    input  logic        data_busy,
    input  logic        id_ldhazard,
    input  logic        ex_div,
    input  logic        mem_exc,
    output logic        pc_stall,
    output logic        pc_refresh,
    output logic        if_id_stall,
    output logic        if_id_refresh,
    output logic        id_ex_stall,
    output logic        id_ex_refresh,
    output logic        ex_mem_stall,
    output logic        ex_mem_refresh,
    output logic        mem_wb_stall,
    output logic        mem_wb_refresh,
    output logic        div_done,
    output logic        inst_discard,
    output logic [31:0] stall_cycles
);

    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV_CYCLES - 1);
    localparam logic [DIV_CNT_W-1:0] CNT_ONE  = DIV_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DIV   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DIV_CNT_W-1:0]   r_div_cnt;
    logic [DIV_CNT_W-1:0]   w_div_cnt_nxt;

    // State and divide counter register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= ST_RUN;
            r_div_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_cnt_nxt;
        end
    end

    // Prioritised hazard resolution; only the highest active condition drives the pipeline
    always_comb begin
        pc_stall       = 1'b0;
        pc_refresh     = 1'b0;
        if_id_stall    = 1'b0;
        if_id_refresh  = 1'b0;
        id_ex_stall    = 1'b0;
        id_ex_refresh  = 1'b0;
        ex_mem_stall   = 1'b0;
        ex_mem_refresh = 1'b0;
        mem_wb_stall   = 1'b0;
        mem_wb_refresh = 1'b0;
        div_done       = 1'b0;
        inst_discard   = (r_state == ST_DRAIN);
        w_state_nxt    = r_state;
        w_div_cnt_nxt  = r_div_cnt;

        // The dropped response lands in the cycle inst_busy is seen low
        if (r_state == ST_DRAIN && !inst_busy) begin
            w_state_nxt = ST_RUN;
        end

        if (!resetn) begin
            pc_refresh     = 1'b1;
            if_id_refresh  = 1'b1;
            id_ex_refresh  = 1'b1;
            ex_mem_refresh = 1'b1;
            mem_wb_refresh = 1'b1;
            inst_discard   = 1'b0;
            w_state_nxt    = ST_RUN;
            w_div_cnt_nxt  = '0;
        end else if (mem_exc) begin
            // WB of the excepting instruction is suppressed by CP0, so mem_wb is left alone
            pc_refresh     = 1'b1;
            if_id_refresh  = 1'b1;
            id_ex_refresh  = 1'b1;
            ex_mem_refresh = 1'b1;
            w_div_cnt_nxt  = '0;
            w_state_nxt    = inst_busy ? ST_DRAIN : ST_RUN;
        end else if (data_busy) begin
            pc_stall       = 1'b1;
            if_id_stall    = 1'b1;
            id_ex_stall    = 1'b1;
            ex_mem_stall   = 1'b1;
            mem_wb_refresh = 1'b1;
            // Divider keeps running; hold at the last count until the memory stall clears
            if (r_state == ST_DIV && r_div_cnt != DIV_LAST) begin
                w_div_cnt_nxt = r_div_cnt + CNT_ONE;
            end
        end else if (r_state == ST_DIV || (r_state == ST_RUN && ex_div)) begin
            if (r_state == ST_DIV && r_div_cnt == DIV_LAST) begin
                div_done      = 1'b1;
                w_state_nxt   = ST_RUN;
                w_div_cnt_nxt = '0;
            end else begin
                pc_stall       = 1'b1;
                if_id_stall    = 1'b1;
                id_ex_stall    = 1'b1;
                ex_mem_refresh = 1'b1;
                w_state_nxt    = ST_DIV;
                w_div_cnt_nxt  = (r_state == ST_DIV) ? (r_div_cnt + CNT_ONE) : CNT_ONE;
            end
        end else if (id_ldhazard) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_refresh = 1'b1;
        end else if (inst_busy || r_state == ST_DRAIN) begin
            pc_stall      = 1'b1;
            if_id_refresh = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    // Counts every cycle the PC is held; wraps naturally
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stall_cycles <= 32'd0;
        end else if (pc_stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 32'b0;
`endif

`ifndef SYNTHESIS
    generate
        if (DIV_CYCLES < 2 || DIV_CYCLES > 63 || DIV_CYCLES > (2 ** DIV_CNT_W)) begin : g_bad_cfg
            $error("pipe_hazard_ctrl: DIV_CYCLES out of range for DIV_CNT_W");
        end
    endgenerate

    a_pc_excl: assert property (@(posedge clk) disable iff (!resetn) !(pc_stall && pc_refresh));
    a_done_pulse: assert property (@(posedge clk) disable iff (!resetn) div_done |=> !div_done);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver queues expected per-cycle outputs, monitor compares.
module tb_pipe_hazard_ctrl;

    // Expected vector pairs: {pc s/r, if_id s/r, id_ex s/r, ex_mem s/r, mem_wb s/r, div_done/inst_discard}
    localparam logic [11:0] E_IDLE = 12'b00_00_00_00_00_00;
    localparam logic [11:0] E_RST  = 12'b01_01_01_01_01_00;
    localparam logic [11:0] E_EXC  = 12'b01_01_01_01_00_00;
    localparam logic [11:0] E_EXCD = 12'b01_01_01_01_00_01;
    localparam logic [11:0] E_DBSY = 12'b10_10_10_10_01_00;
    localparam logic [11:0] E_DIV  = 12'b10_10_10_01_00_00;
    localparam logic [11:0] E_DONE = 12'b00_00_00_00_00_10;
    localparam logic [11:0] E_LDH  = 12'b10_10_01_00_00_00;
    localparam logic [11:0] E_IBSY = 12'b10_01_00_00_00_00;
    localparam logic [11:0] E_DRN  = 12'b10_01_00_00_00_01;

    // Input vector: {inst_busy, data_busy, id_ldhazard, ex_div, mem_exc}
    localparam logic [4:0] I_NONE = 5'b00000;
    localparam logic [4:0] I_IB   = 5'b10000;
    localparam logic [4:0] I_DB   = 5'b01000;
    localparam logic [4:0] I_LH   = 5'b00100;
    localparam logic [4:0] I_XD   = 5'b00010;
    localparam logic [4:0] I_EX   = 5'b00001;

    typedef struct {
        logic [11:0] vec;
        logic [31:0] sc;
        logic        sc_chk;
        string       name;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        inst_busy, data_busy, id_ldhazard, ex_div, mem_exc;
    logic        pc_stall, pc_refresh, if_id_stall, if_id_refresh, id_ex_stall, id_ex_refresh;
    logic        ex_mem_stall, ex_mem_refresh, mem_wb_stall, mem_wb_refresh, div_done, inst_discard;
    logic [31:0] stall_cycles;

    exp_t        q[$];
    exp_t        m_e;
    logic [11:0] got;
    logic [31:0] m_sc;
    logic        m_known;
    int          errors;
    int          checks;

    pipe_hazard_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .inst_busy      (inst_busy),
        .data_busy      (data_busy),
        .id_ldhazard    (id_ldhazard),
        .ex_div         (ex_div),
        .mem_exc        (mem_exc),
        .pc_stall       (pc_stall),
        .pc_refresh     (pc_refresh),
        .if_id_stall    (if_id_stall),
        .if_id_refresh  (if_id_refresh),
        .id_ex_stall    (id_ex_stall),
        .id_ex_refresh  (id_ex_refresh),
        .ex_mem_stall   (ex_mem_stall),
        .ex_mem_refresh (ex_mem_refresh),
        .mem_wb_stall   (mem_wb_stall),
        .mem_wb_refresh (mem_wb_refresh),
        .div_done       (div_done),
        .inst_discard   (inst_discard),
        .stall_cycles   (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle of stimulus: drive after the edge, queue what this cycle must show
    task automatic step(input logic rn, input logic [4:0] in, input logic [11:0] ev,
                        input string nm, input bit preset = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        resetn = rn;
        {inst_busy, data_busy, id_ldhazard, ex_div, mem_exc} = in;
`ifdef HAZARD_PERF_CNT_EN
        if (preset) begin
            dut.r_stall_cycles = 32'hFFFF_FFFF;
            m_sc = 32'hFFFF_FFFF;
        end
`else
        if (preset) m_sc = 32'd0;
`endif
        e.vec    = ev;
        e.sc     = m_sc;
        e.sc_chk = m_known;
        e.name   = nm;
        q.push_back(e);
        if (!rn) begin
            m_sc    = 32'd0;
            m_known = 1'b1;
        end
`ifdef HAZARD_PERF_CNT_EN
        else if (ev[11]) begin
            m_sc = m_sc + 32'd1;
        end
`endif
    endtask

    task automatic run(input int n, input logic rn, input logic [4:0] in,
                       input logic [11:0] ev, input string nm);
        for (int i = 0; i < n; i++) step(rn, in, ev, nm);
    endtask

    // Monitor: outputs are combinational, compared mid-cycle on the falling edge
    always @(negedge clk) begin
        if (q.size() != 0) begin
            m_e = q.pop_front();
            got = {pc_stall, pc_refresh, if_id_stall, if_id_refresh, id_ex_stall, id_ex_refresh,
                   ex_mem_stall, ex_mem_refresh, mem_wb_stall, mem_wb_refresh, div_done, inst_discard};
            checks = checks + 1;
            if (got !== m_e.vec || (m_e.sc_chk && stall_cycles !== m_e.sc)) begin
                errors = errors + 1;
                $display("FAIL %s @%0t: got outputs=%b stall_cycles=%h, expected outputs=%b stall_cycles=%h",
                         m_e.name, $time, got, stall_cycles, m_e.vec, m_e.sc);
            end
        end
    end

    initial begin
        errors      = 0;
        checks      = 0;
        m_sc        = 32'd0;
        m_known     = 1'b0;
        resetn      = 1'b0;
        inst_busy   = 1'b0;
        data_busy   = 1'b0;
        id_ldhazard = 1'b0;
        ex_div      = 1'b0;
        mem_exc     = 1'b0;

        run(3, 1'b0, I_NONE, E_RST, "reset");
        run(2, 1'b1, I_NONE, E_IDLE, "idle_after_reset");

        // Full divide (with a coincident load-use hazard), then a back-to-back divide
        step(1'b1, I_XD | I_LH, E_DIV, "div_beats_ldhazard");
        run(31, 1'b1, I_XD, E_DIV, "div_stall");
        step(1'b1, I_XD, E_DONE, "div_done");
        run(32, 1'b1, I_XD, E_DIV, "div_restart");
        step(1'b1, I_XD, E_DONE, "div_done_restart");
        step(1'b1, I_NONE, E_IDLE, "div_idle");

        step(1'b1, I_LH, E_LDH, "ldhazard");
        step(1'b1, I_NONE, E_IDLE, "ldhazard_clear");

        // Exception at divide cycle 10 aborts the divide
        run(9, 1'b1, I_XD, E_DIV, "div_pre_exc");
        step(1'b1, I_XD | I_EX, E_EXC, "exc_abort_div");
        run(34, 1'b1, I_NONE, E_IDLE, "no_div_done_after_exc");

        // Exception with a fetch outstanding: drain and discard
        step(1'b1, I_EX | I_IB, E_EXC, "exc_fetch_busy");
        run(4, 1'b1, I_IB, E_DRN, "drain");
        step(1'b1, I_NONE, E_DRN, "drain_fall");
        step(1'b1, I_NONE, E_IDLE, "drain_exit");
        step(1'b1, I_IB, E_IBSY, "fetch_busy_run");

        // Exception repeated while draining
        step(1'b1, I_EX | I_IB, E_EXC, "exc2");
        step(1'b1, I_IB, E_DRN, "drain2");
        step(1'b1, I_EX | I_IB, E_EXCD, "exc_in_drain");
        step(1'b1, I_IB, E_DRN, "drain_after_exc");
        step(1'b1, I_NONE, E_DRN, "drain2_fall");
        step(1'b1, I_NONE, E_IDLE, "drain2_exit");

        // Memory stall during a divide: counter holds at the last count, done after release
        run(5, 1'b1, I_XD, E_DIV, "div_pre_dbusy");
        run(40, 1'b1, I_XD | I_DB, E_DBSY, "dbusy_in_div");
        step(1'b1, I_XD, E_DONE, "div_done_after_dbusy");
        step(1'b1, I_NONE, E_IDLE, "dbusy_div_idle");

        // Reset mid-divide and mid-drain
        run(5, 1'b1, I_XD, E_DIV, "div_pre_reset");
        step(1'b0, I_XD, E_RST, "reset_mid_div");
        run(35, 1'b1, I_NONE, E_IDLE, "no_done_after_reset");
        step(1'b1, I_EX | I_IB, E_EXC, "exc3");
        step(1'b1, I_IB, E_DRN, "drain3");
        step(1'b0, I_IB, E_RST, "reset_mid_drain");
        step(1'b1, I_IB, E_IBSY, "no_discard_after_reset");
        step(1'b1, I_NONE, E_IDLE, "idle_after_drain_reset");

        // Stall-cycle counter: 7 memory stalls plus one load-use cycle, then wrap
        step(1'b0, I_NONE, E_RST, "perf_reset");
        run(7, 1'b1, I_DB, E_DBSY, "perf_dbusy");
        step(1'b1, I_LH, E_LDH, "perf_ldhazard");
        step(1'b1, I_NONE, E_IDLE, "perf_count8");
        step(1'b1, I_LH, E_LDH, "perf_preset", 1'b1);
        step(1'b1, I_NONE, E_IDLE, "perf_wrap");

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors = errors + 1;
            checks = checks + 1;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline.
- Drives the stall/refresh pair of every pipeline register: pc, if_id, id_ex, ex_mem, mem_wb.
- Sequences multi-cycle divides in EX and load-use interlocks.
- Redirects on exception/eret committing in MEM, and drains/discards an in-flight instruction fetch after a redirect.

Parameters:
DIV_CYCLES, 33, cycles the iterative divider occupies EX (range 2..63)
DIV_CNT_W, 6, width of divide cycle counter

Ports:
clk  in  1  clock
resetn  in  1  reset; synchronous, active-low
inst_busy  in  1  instruction fetch issued, response not yet returned
data_busy  in  1  MEM-stage data access outstanding
id_ldhazard  in  1  ID instruction sources a register loaded by the instruction in EX
ex_div  in  1  valid DIV/DIVU occupies EX
mem_exc  in  1  exception or eret committing in MEM this cycle
pc_stall / pc_refresh  out  1/1  PC register hold / reset-to-redirect
if_id_stall / if_id_refresh  out  1/1  IF/ID hold / bubble
id_ex_stall / id_ex_refresh  out  1/1  ID/EX hold / bubble
ex_mem_stall / ex_mem_refresh  out  1/1  EX/MEM hold / bubble
mem_wb_stall / mem_wb_refresh  out  1/1  MEM/WB hold / bubble
div_done  out  1  one-cycle pulse: quotient/remainder valid in EX
inst_discard  out  1  next fetch response must be dropped
stall_cycles  out  32  perf counter (see Optional Feature)

Behaviour:
- FSM states: RUN, DIV, DRAIN. Divide counter div_cnt, DIV_CNT_W bits.
- Reset, while resetn=0:
  - all *_refresh=1, all *_stall=0, div_done=0, inst_discard=0.
  - Next state RUN, div_cnt=0.
- All stall/refresh outputs are combinational from state and inputs. State updates on posedge clk.
- Priority of conditions, highest first; only the highest active condition drives the outputs:
  1. mem_exc: refresh if_id, id_ex, ex_mem; mem_wb refresh=0 (the excepting instruction's WB is suppressed by CP0 logic, not here); pc_refresh=1 (load vector/EPC).
     - Any DIV state aborts to RUN with div_cnt=0.
     - If inst_busy=1: go to DRAIN; else go to RUN.
  2. data_busy: stall pc, if_id, id_ex, ex_mem; refresh mem_wb.
     - div_cnt keeps counting in DIV.
  3. DIV state, or RUN with ex_div=1: stall pc, if_id, id_ex; refresh ex_mem.
     - RUN with ex_div=1: enter DIV, div_cnt=1.
     - In DIV: div_cnt increments each cycle.
     - When div_cnt==DIV_CYCLES-1: div_done=1 this cycle, stalls released (ex_mem takes result), return to RUN, div_cnt=0.
     - ex_div still high in the cycle after div_done belongs to a new divide and restarts the sequence.
  4. id_ldhazard: stall pc, if_id; refresh id_ex. Exactly one bubble per hazard cycle.
  5. inst_busy, or DRAIN state: stall pc; refresh if_id.
- DRAIN state:
  - inst_discard=1.
  - Leave to RUN in the cycle inst_busy falls. The dropped response arrives in that cycle with inst_discard still 1.
  - pc is not refreshed again.
  - mem_exc during DRAIN repeats rule 1 and stays in DRAIN.
- Simultaneous events:
  - mem_exc with data_busy: mem_exc wins. The MEM access is not ours to cancel; the bus master guarantees data_busy=0 when mem_exc asserts.
  - ex_div with id_ldhazard: divide wins; the hazard re-evaluates after div_done.
- Reset mid-divide or mid-drain: immediate return to RUN, counter cleared, no div_done pulse.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles is a 32-bit counter, reset to 0.
  - Increments every cycle pc_stall=1.
  - Wraps 0xFFFFFFFF -> 0.
- Undefined: stall_cycles tied to 32'b0; no counter flops.

Test Plan:
- Reset held 3 cycles, then released with idle inputs -> all refresh=1 during reset, then all outputs 0, state RUN.
- ex_div=1 held, DIV_CYCLES=33 -> ex_mem_refresh=1 and pc/if_id/id_ex stall=1 for 32 cycles; div_done on cycle 33 of the divide with stalls low; single pulse.
- id_ldhazard one cycle -> pc_stall=if_id_stall=id_ex_refresh=1 for exactly that cycle.
- mem_exc at divide cycle 10 -> pc_refresh and if_id/id_ex/ex_mem refresh=1; no div_done ever; state RUN next cycle (inst_busy=0).
- mem_exc with inst_busy=1, inst_busy falling 4 cycles later -> inst_discard=1 for those 4 cycles plus the falling cycle; if_id_refresh=1 throughout; pc_refresh only in the exception cycle.
- HAZARD_PERF_CNT_EN defined, data_busy held 7 cycles plus 1 load-use cycle -> stall_cycles=8; counter preset to 0xFFFFFFFF plus 1 stall cycle -> 0.
